// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Frame constants are used by both the transmit and receive paths; the
// receiver state type and holding-register layout live here so the
// transmitter and any debug logic can refer to the same encoding.
package uart_pkg;
  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  // Byte plus the error flags that belong to it; committed together.
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 frame_err;
    logic                 parity_err;
  } rx_hold_t;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, forces both flops to RESET_VAL
//   d     - asynchronous input
//   q     - synchronized output, two cycles of latency
// RESET_VAL defaults to the serial idle level so a line that is idle
// through reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = IDLE_LEVEL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 or 8E1, LSB first.
// Ports:
//   clk_i        - system clock
//   reset_ni     - asynchronous active-low reset
//   rx_i         - serial input, idle high, asynchronous to clk_i
//   read_i       - consumer pulse, clears valid_o and overrun_o
//   data_o       - last received byte
//   valid_o      - holding register holds an unread byte
//   frame_err_o  - stop bit of data_o sampled low
//   parity_err_o - even-parity mismatch on data_o (0 when PARITY_EN=0)
//   overrun_o    - sticky, a byte was committed over an unread one
//   busy_o       - a frame is being received
// Bits are sampled mid-bit: the start bit is re-checked HALF cycles after
// the falling edge, every later bit one full bit time after that.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 rx_i,
  input  logic                 read_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);
  localparam int             HALF     = CLKS_PER_BIT / 2;
  localparam int             BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  HALF_M1  = BW'(HALF - 1);
  localparam logic [BW-1:0]  FULL_M1  = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            state, state_n;
  logic [BW-1:0]        baud_cnt, baud_n;
  logic [2:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr, perr_n;
  logic                 commit;
  logic                 rx_s;
  rx_hold_t             hold;

  uart_rx_sync u_sync (
    .clk   (clk_i),
    .rst_n (reset_ni),
    .d     (rx_i),
    .q     (rx_s)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      perr     <= perr_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    perr_n  = perr;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          baud_n  = '0;
        end
      end
      START: begin
        baud_n = baud_cnt + 1'b1;
        if (baud_cnt == HALF_M1) begin
          baud_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            bit_n   = '0;
            perr_n  = 1'b0;
          end else begin
            // line went back high before mid-start: a glitch, not a frame
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        baud_n = baud_cnt + 1'b1;
        if (baud_cnt == FULL_M1) begin
          baud_n  = '0;
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) state_n = PARITY_EN ? PARITY : STOP;
          else                     bit_n   = bit_cnt + 3'd1;
        end
      end
      PARITY: begin
        baud_n = baud_cnt + 1'b1;
        if (baud_cnt == FULL_M1) begin
          baud_n  = '0;
          perr_n  = (^shreg) ^ rx_s;
          state_n = STOP;
        end
      end
      STOP: begin
        baud_n = baud_cnt + 1'b1;
        if (baud_cnt == FULL_M1) begin
          baud_n  = '0;
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A commit always wins over a coincident read; overrun only flags a byte
  // that was overwritten without ever being acknowledged.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hold      <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (commit) begin
      hold      <= '{data: shreg, frame_err: ~rx_s, parity_err: PARITY_EN && perr};
      valid_o   <= 1'b1;
      if (valid_o && !read_i) overrun_o <= 1'b1;
    end else if (read_i && valid_o) begin
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end
  end

  assign data_o       = hold.data;
  assign frame_err_o  = hold.frame_err;
  assign parity_err_o = hold.parity_err;
  assign busy_o       = (state != IDLE);
endmodule
